// File: rtl/lockstep_checker.sv
// Lockstep checker: after each change on the monitored clock/reset, waits SETTLE
// cycles and compares two observed outputs, reporting and counting mismatches.
module lockstep_checker #(
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             obs_a,
    input  logic             obs_b,
    input  logic             mon_clk,
    input  logic             mon_rst,
    output logic             error,
    output logic             stop,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cmp_count,
    output logic             first_err_valid,
    output logic [3:0]       first_err_snap
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMP} state_t;

    localparam int unsigned SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [7:0]  RELOAD      = 8'(SETTLE_M1);
    localparam logic        ZERO_SETTLE = (SETTLE == 0);
    localparam logic        ONE_SETTLE  = (SETTLE == 1);
    localparam logic        STOP_EN     = (STOP_ON_ERR != 0);

    state_t     state;
    logic [7:0] settle_cnt;   // cycles still to wait in S_WAIT before S_CMP
    logic       prev_clk;
    logic       prev_rst;

    logic       ev;
    logic       cmp_now;
    logic       mismatch;
    state_t     start_state;

    // Event detection and compare qualification for the current cycle
    always_comb begin
        ev       = enable && !stop && ((mon_clk != prev_clk) || (mon_rst != prev_rst));
        cmp_now  = enable && !stop && ((state == S_CMP) || (ZERO_SETTLE && ev));
        mismatch = cmp_now && (obs_a != obs_b);
        if (ZERO_SETTLE) begin
            start_state = S_IDLE;
        end else if (ONE_SETTLE) begin
            start_state = S_CMP;
        end else begin
            start_state = S_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            settle_cnt      <= '0;
            prev_clk        <= mon_clk;
            prev_rst        <= mon_rst;
            error           <= 1'b0;
            stop            <= 1'b0;
            err_count       <= '0;
            cmp_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_snap  <= 4'b0;
        end else begin
            prev_clk <= mon_clk;
            prev_rst <= mon_rst;
            error    <= mismatch;

            if (mismatch && STOP_EN) begin
                stop <= 1'b1;
            end
            if (cmp_now && (cmp_count != '1)) begin
                cmp_count <= cmp_count + CNT_W'(1);
            end
            if (mismatch && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_snap  <= {obs_a, obs_b, mon_clk, mon_rst};
            end

            // Window FSM; a new event always restarts the window
            if (!enable || stop) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_CMP: begin
                        if (ev) begin
                            state      <= start_state;
                            settle_cnt <= RELOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_WAIT: begin
                        if (ev) begin
                            state      <= start_state;
                            settle_cnt <= RELOAD;
                        end else if (settle_cnt <= 8'd1) begin
                            state <= S_CMP;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: several parameterisations share one
// stimulus bus; each scenario checks the instance it targets.
module tb_lockstep_checker;

    logic clk = 1'b0;
    logic reset, enable, obs_a, obs_b, mon_clk, mon_rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic d1_error, d1_stop, d1_fev; logic [15:0] d1_err, d1_cmp; logic [3:0] d1_snap;
    logic d2_error, d2_stop, d2_fev; logic [15:0] d2_err, d2_cmp; logic [3:0] d2_snap;
    logic d3_error, d3_stop, d3_fev; logic [15:0] d3_err, d3_cmp; logic [3:0] d3_snap;
    logic dn_error, dn_stop, dn_fev; logic [15:0] dn_err, dn_cmp; logic [3:0] dn_snap;
    logic ds_error, ds_stop, ds_fev; logic [1:0]  ds_err, ds_cmp; logic [3:0] ds_snap;

    lockstep_checker u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .obs_a(obs_a), .obs_b(obs_b),
        .mon_clk(mon_clk), .mon_rst(mon_rst), .error(d1_error), .stop(d1_stop),
        .err_count(d1_err), .cmp_count(d1_cmp), .first_err_valid(d1_fev), .first_err_snap(d1_snap));

    lockstep_checker #(.SETTLE(2)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .obs_a(obs_a), .obs_b(obs_b),
        .mon_clk(mon_clk), .mon_rst(mon_rst), .error(d2_error), .stop(d2_stop),
        .err_count(d2_err), .cmp_count(d2_cmp), .first_err_valid(d2_fev), .first_err_snap(d2_snap));

    lockstep_checker #(.SETTLE(3)) u_d3 (
        .clk(clk), .reset(reset), .enable(enable), .obs_a(obs_a), .obs_b(obs_b),
        .mon_clk(mon_clk), .mon_rst(mon_rst), .error(d3_error), .stop(d3_stop),
        .err_count(d3_err), .cmp_count(d3_cmp), .first_err_valid(d3_fev), .first_err_snap(d3_snap));

    lockstep_checker #(.SETTLE(1), .STOP_ON_ERR(0)) u_dn (
        .clk(clk), .reset(reset), .enable(enable), .obs_a(obs_a), .obs_b(obs_b),
        .mon_clk(mon_clk), .mon_rst(mon_rst), .error(dn_error), .stop(dn_stop),
        .err_count(dn_err), .cmp_count(dn_cmp), .first_err_valid(dn_fev), .first_err_snap(dn_snap));

    lockstep_checker #(.SETTLE(0), .CNT_W(2), .STOP_ON_ERR(0)) u_ds (
        .clk(clk), .reset(reset), .enable(enable), .obs_a(obs_a), .obs_b(obs_b),
        .mon_clk(mon_clk), .mon_rst(mon_rst), .error(ds_error), .stop(ds_stop),
        .err_count(ds_err), .cmp_count(ds_cmp), .first_err_valid(ds_fev), .first_err_snap(ds_snap));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset   = 1'b1;
        enable  = 1'b1;
        obs_a   = 1'b0;
        obs_b   = 1'b0;
        mon_clk = 1'b0;
        mon_rst = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset_dut();
        check("rst_d1_error", 32'(d1_error), 32'd0);
        check("rst_d1_stop",  32'(d1_stop),  32'd0);
        check("rst_d1_err",   32'(d1_err),   32'd0);
        check("rst_d1_cmp",   32'(d1_cmp),   32'd0);
        check("rst_d1_fev",   32'(d1_fev),   32'd0);
        check("rst_d1_snap",  32'(d1_snap),  32'd0);

        // SETTLE=1, equal outputs: one compare, no error pulse
        mon_clk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s1_error", 32'(d1_error), 32'd0);
        end
        check("s1_cmp",  32'(d1_cmp),  32'd1);
        check("s1_err",  32'(d1_err),  32'd0);
        check("s1_stop", 32'(d1_stop), 32'd0);
        check("s1_fev",  32'(d1_fev),  32'd0);

        // SETTLE=2, obs_b differs only in the compare cycle
        reset_dut();
        mon_clk = 1'b1;
        tick();
        check("s2_t_error", 32'(d2_error), 32'd0);
        tick();
        check("s2_t1_cmp", 32'(d2_cmp), 32'd0);
        obs_b = 1'b1;
        tick();
        check("s2_error", 32'(d2_error), 32'd1);
        check("s2_err",   32'(d2_err),   32'd1);
        check("s2_cmp",   32'(d2_cmp),   32'd1);
        check("s2_stop",  32'(d2_stop),  32'd1);
        check("s2_fev",   32'(d2_fev),   32'd1);
        check("s2_snap",  32'(d2_snap),  32'b0110);
        obs_b = 1'b0;
        tick();
        check("s2_pulse_end", 32'(d2_error), 32'd0);
        check("s2_sticky",    32'(d2_stop),  32'd1);
        mon_clk = 1'b0;
        tick(); tick(); tick();
        check("s2_halt_cmp", 32'(d2_cmp), 32'd1);
        check("s2_halt_err", 32'(d2_err), 32'd1);

        // SETTLE=3, second event two cycles later restarts the window
        reset_dut();
        mon_clk = 1'b1;
        tick();
        tick();
        mon_clk = 1'b0;
        tick();
        tick();
        check("s3_t3_cmp", 32'(d3_cmp), 32'd0);
        tick();
        check("s3_t4_cmp", 32'(d3_cmp), 32'd0);
        tick();
        check("s3_t5_cmp", 32'(d3_cmp), 32'd1);
        tick(); tick(); tick();
        check("s3_single", 32'(d3_cmp), 32'd1);

        // STOP_ON_ERR=0, three mismatches; snapshot keeps the first
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            mon_clk = ~mon_clk;
            tick();
            obs_a = (k != 1);
            obs_b = (k == 1);
            tick();
            check("s4_error", 32'(dn_error), 32'd1);
            obs_a = 1'b0;
            obs_b = 1'b0;
            tick();
        end
        check("s4_err",  32'(dn_err),  32'd3);
        check("s4_cmp",  32'(dn_cmp),  32'd3);
        check("s4_stop", 32'(dn_stop), 32'd0);
        check("s4_snap", 32'(dn_snap), 32'b1010);

        // Enable dropped mid-window: no compare
        reset_dut();
        obs_b   = 1'b1;
        mon_clk = 1'b1;
        tick();
        enable = 1'b0;
        tick(); tick(); tick();
        enable = 1'b1;
        tick(); tick(); tick();
        check("s5_cmp",   32'(d2_cmp),   32'd0);
        check("s5_err",   32'(d2_err),   32'd0);
        check("s5_error", 32'(d2_error), 32'd0);

        // Reset while in WAIT clears everything
        reset_dut();
        obs_b   = 1'b1;
        mon_clk = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        check("s6_cmp",  32'(d3_cmp),  32'd0);
        check("s6_err",  32'(d3_err),  32'd0);
        check("s6_stop", 32'(d3_stop), 32'd0);
        check("s6_fev",  32'(d3_fev),  32'd0);
        check("s6_snap", 32'(d3_snap), 32'd0);

        // SETTLE=0, CNT_W=2: compare in event cycle, counters saturate
        reset_dut();
        obs_a   = 1'b1;
        mon_rst = 1'b1;
        tick();
        check("s7_error", 32'(ds_error), 32'd1);
        check("s7_err1",  32'(ds_err),   32'd1);
        check("s7_cmp1",  32'(ds_cmp),   32'd1);
        check("s7_snap",  32'(ds_snap),  32'b1001);
        for (int k = 0; k < 4; k++) begin
            mon_clk = ~mon_clk;
            tick();
        end
        tick();
        check("s7_err_sat", 32'(ds_err),  32'd3);
        check("s7_cmp_sat", 32'(ds_cmp),  32'd3);
        check("s7_snap_kp", 32'(ds_snap), 32'b1001);
        check("s7_stop",    32'(ds_stop), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lockstep_checker.md
LOCKSTEP_CHECKER -- requirements
Module: lockstep_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1: cycles from a monitored event to its compare cycle (legal range 0..255).
REQ-002 SHALL have parameter CNT_W, default 16: width of the error and compare counters.
REQ-003 SHALL have parameter STOP_ON_ERR, default 1: 1 = halt comparing after the first mismatch.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: checking enabled when 1.
REQ-007 SHALL have port obs_a, input, 1 bit: first observed DUT output.
REQ-008 SHALL have port obs_b, input, 1 bit: second observed DUT output.
REQ-009 SHALL have port mon_clk, input, 1 bit: monitored stimulus clock, sampled as data.
REQ-010 SHALL have port mon_rst, input, 1 bit: monitored stimulus reset, sampled as data.
REQ-011 SHALL have port error, output, 1 bit: one-cycle pulse per detected mismatch.
REQ-012 SHALL have port stop, output, 1 bit: sticky halt flag.
REQ-013 SHALL have port err_count, output, CNT_W bits: mismatches seen, saturating.
REQ-014 SHALL have port cmp_count, output, CNT_W bits: compares performed, saturating.
REQ-015 SHALL have port first_err_valid, output, 1 bit: first_err_snap holds valid data.
REQ-016 SHALL have port first_err_snap, output, 4 bits: {obs_a, obs_b, mon_clk, mon_rst} at the first mismatch.

Function
REQ-017 SHALL register mon_clk and mon_rst each cycle into prev_clk and prev_rst.
REQ-018 SHALL declare an event in any cycle where enable=1, stop=0 and (mon_clk!=prev_clk or mon_rst!=prev_rst).
REQ-019 SHALL implement FSM IDLE -> WAIT -> CMP -> IDLE; an event in IDLE loads settle counter with SETTLE and enters WAIT.
REQ-020 SHALL decrement the settle counter in WAIT and enter CMP when it reaches zero; compare cycle = event cycle + SETTLE.
REQ-021 SHALL, when SETTLE=0, perform the compare in the event cycle itself (WAIT is skipped).
REQ-022 SHALL restart the window (reload SETTLE, stay in WAIT) on a new event while in WAIT; only one compare results.
REQ-023 SHALL treat an event coinciding with a compare as starting a new window after that compare.
REQ-024 SHALL compare obs_a against obs_b in the compare cycle; a difference is a mismatch.
REQ-025 SHALL increment cmp_count on every compare, saturating at all-ones.
REQ-026 SHALL, on mismatch, pulse error high in the cycle after the compare cycle.
REQ-027 SHALL, on mismatch, increment err_count in that same following cycle, saturating at all-ones.
REQ-028 SHALL, on the first mismatch only, capture first_err_snap from the compare-cycle inputs and set first_err_valid.
REQ-029 SHALL, when STOP_ON_ERR=1, set stop with error; stop then blocks events and returns the FSM to IDLE.
REQ-030 SHALL, when enable falls, abort any pending window to IDLE without comparing; prev registers keep tracking.

Reset
REQ-031 SHALL, on reset=1, clear state to IDLE and clear error, stop, err_count, cmp_count, first_err_valid and first_err_snap.
REQ-032 SHALL, on reset=1, load prev_clk and prev_rst from mon_clk and mon_rst, so the first post-reset cycle raises no spurious event.
REQ-033 SHALL give reset priority over all events and compares, including a reset asserted mid-window.

Verification
REQ-034 SHALL cover: SETTLE=1, toggle mon_clk with obs_a=obs_b -> cmp_count=1, error never asserts.
REQ-035 SHALL cover: SETTLE=2, mon_clk edge at cycle t, obs_b differs only at t+2 -> error at t+3, err_count=1, snap captured, stop=1.
REQ-036 SHALL cover: SETTLE=3, second event at t+2 -> single compare at t+5, cmp_count=1.
REQ-037 SHALL cover: STOP_ON_ERR=0, three mismatches -> err_count=3 and snap holds the first mismatch.
REQ-038 SHALL cover: enable dropped mid-window -> no compare; reset at WAIT -> all outputs return to 0.
REQ-039 SHALL cover: CNT_W=2, five mismatching compares -> err_count=3 (saturated).
